// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Instruction-fetch stage: PC owner, 1-cycle imem requester,
//            credit-controlled skid FIFO and redirect flush.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    BUF_DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_ready,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    output logic [INSTR_WIDTH-1:0] if_instr
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_FLUSH = 2'd2;

    // Storage is sized for the largest legal depth; only BUF_DEPTH slots are used.
    localparam int                    c_SLOTS    = 4;
    localparam logic [1:0]            c_PTR_LAST = 2'(BUF_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] c_WORD_MSK = ~(ADDR_WIDTH'(3));

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  w_pc_nxt;
    logic [ADDR_WIDTH-1:0]  r_issued_pc;
    logic [2:0]             r_count;
    logic                   r_inflight;
    logic                   r_discard;
    logic [1:0]             r_head;
    logic [1:0]             r_tail;
    logic [ADDR_WIDTH-1:0]  r_buf_pc    [c_SLOTS];
    logic [INSTR_WIDTH-1:0] r_buf_instr [c_SLOTS];

    logic                   w_pop;
    logic                   w_push;
    logic                   w_req;
    logic                   w_flush;
    logic [3:0]             w_free;
    logic [ADDR_WIDTH-1:0]  w_target;

    function automatic logic [1:0] f_ptr_inc(input logic [1:0] ptr);
        return (ptr == c_PTR_LAST) ? 2'd0 : ptr + 2'd1;
    endfunction

    assign if_valid  = (r_count != 3'd0);
    assign if_pc     = r_buf_pc[r_head];
    assign if_instr  = r_buf_instr[r_head];
    assign imem_req  = w_req;
    assign imem_addr = r_pc;

    always_comb begin
        w_pop    = if_valid & id_ready;
        // count + inflight never exceeds BUF_DEPTH, so this cannot go negative.
        w_free   = 4'(BUF_DEPTH) + 4'(w_pop) - 4'(r_count) - 4'(r_inflight);
        w_target = redirect_pc & c_WORD_MSK;
        w_flush  = redirect_valid && (r_state != c_ST_IDLE);
        w_req    = (r_state == c_ST_FETCH) && (w_free != 4'd0) && !redirect_valid;
        w_push   = r_inflight && !r_discard && (r_state == c_ST_FETCH) && !redirect_valid;

        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  w_state_nxt = c_ST_FETCH;
            c_ST_FETCH: w_state_nxt = redirect_valid ? c_ST_FLUSH : c_ST_FETCH;
            c_ST_FLUSH: w_state_nxt = redirect_valid ? c_ST_FLUSH : c_ST_FETCH;
            default:    w_state_nxt = c_ST_IDLE;
        endcase

        // A redirect seen in IDLE just retargets the first fetch.
        w_pc_nxt = r_pc;
        if (redirect_valid) begin
            w_pc_nxt = w_target;
        end else if (w_req) begin
            w_pc_nxt = r_pc + ADDR_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_pc        <= RESET_PC;
            r_issued_pc <= '0;
            r_count     <= 3'd0;
            r_inflight  <= 1'b0;
            r_discard   <= 1'b0;
            r_head      <= 2'd0;
            r_tail      <= 2'd0;
            for (int i = 0; i < c_SLOTS; i++) begin
                r_buf_pc[i]    <= '0;
                r_buf_instr[i] <= '0;
            end
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_inflight <= w_req;
            r_discard  <= w_flush;
            if (w_req) begin
                r_issued_pc <= r_pc;
            end
            if (w_flush) begin
                r_count <= 3'd0;
                r_head  <= 2'd0;
                r_tail  <= 2'd0;
            end else begin
                if (w_push) begin
                    r_buf_pc[r_tail]    <= r_issued_pc;
                    r_buf_instr[r_tail] <= imem_rdata;
                    r_tail              <= f_ptr_inc(r_tail);
                end
                if (w_pop) begin
                    r_head <= f_ptr_inc(r_head);
                end
                r_count <= r_count + 3'(w_push) - 3'(w_pop);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Brief    : Directed vector bench for fetch_unit with a 1-cycle imem model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    typedef struct {
        logic        rst_n;
        logic        rdy;
        logic        rv;
        logic [31:0] rpc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic        e_zero;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_ready = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        w_rst_n = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic [31:0] w_rdata = '0;
    logic        w_valid;
    logic [31:0] w_pc;
    logic [31:0] w_instr;

    int n_chk  = 0;
    int n_fail = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_unit #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .id_ready(1'b1),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
        .if_valid(w_valid), .if_pc(w_pc), .if_instr(w_instr)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0F0F;
    endfunction

    // Unrequested cycles return junk so a spurious capture is visible.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        w_rdata    <= w_req ? mem_word(w_addr) : 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic rdy, input logic rv, input logic [31:0] rpc,
                       input logic ereq, input logic [31:0] eaddr,
                       input logic evalid, input logic [31:0] epc, input logic ezero);
        vec_t v;
        v.rst_n = r; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
        v.e_req = ereq; v.e_addr = eaddr; v.e_valid = evalid; v.e_pc = epc; v.e_zero = ezero;
        tbl.push_back(v);
    endtask

    logic        wr_req   [7];
    logic [31:0] wr_addr  [7];
    logic        wr_valid [7];
    logic [31:0] wr_pc    [7];

    initial begin
        // reset state, startup and steady stream
        add(0,1,0,0,      0,0,      0,0,      1);
        add(1,1,0,0,      0,0,      0,0,      1);
        add(1,1,0,0,      1,32'h0,  0,0,      0);
        add(1,1,0,0,      1,32'h4,  0,0,      0);
        add(1,1,0,0,      1,32'h8,  1,32'h0,  0);
        add(1,1,0,0,      1,32'hC,  1,32'h4,  0);
        add(1,1,0,0,      1,32'h10, 1,32'h8,  0);
        add(1,1,0,0,      1,32'h14, 1,32'hC,  0);
        // five stall cycles then release
        for (int i = 0; i < 5; i++) add(1,0,0,0, 0,0, 1,32'h10, 0);
        add(1,1,0,0,      1,32'h18, 1,32'h10, 0);
        add(1,1,0,0,      1,32'h1C, 1,32'h14, 0);
        add(1,1,0,0,      1,32'h20, 1,32'h18, 0);
        add(1,1,0,0,      1,32'h24, 1,32'h1C, 0);
        // redirect to 0x100 with one buffered and one in flight
        add(1,1,1,32'h100, 0,0,     1,32'h20, 0);
        add(1,1,0,0,      0,0,      0,0,      0);
        add(1,1,0,0,      1,32'h100,0,0,      0);
        add(1,1,0,0,      1,32'h104,0,0,      0);
        add(1,1,0,0,      1,32'h108,1,32'h100,0);
        add(1,1,0,0,      1,32'h10C,1,32'h104,0);
        // misaligned redirect target
        add(1,1,1,32'h203, 0,0,     1,32'h108,0);
        add(1,1,0,0,      0,0,      0,0,      0);
        add(1,1,0,0,      1,32'h200,0,0,      0);
        add(1,1,0,0,      1,32'h204,0,0,      0);
        add(1,1,0,0,      1,32'h208,1,32'h200,0);
        // back-to-back redirects
        add(1,1,1,32'h40, 0,0,      1,32'h204,0);
        add(1,1,1,32'h80, 0,0,      0,0,      0);
        add(1,1,0,0,      0,0,      0,0,      0);
        add(1,1,0,0,      1,32'h80, 0,0,      0);
        add(1,1,0,0,      1,32'h84, 0,0,      0);
        add(1,1,0,0,      1,32'h88, 1,32'h80, 0);
        // fill FIFO, then reset mid-stream
        add(1,0,0,0,      0,0,      1,32'h84, 0);
        add(1,0,0,0,      0,0,      1,32'h84, 0);
        add(0,0,0,0,      0,0,      1,32'h84, 0);
        add(1,1,0,0,      0,0,      0,0,      1);
        add(1,1,0,0,      1,32'h0,  0,0,      0);
        add(1,1,0,0,      1,32'h4,  0,0,      0);
        add(1,1,0,0,      1,32'h8,  1,32'h0,  0);
        // redirect while in IDLE retargets the first fetch
        add(0,1,0,0,      1,32'hC,  1,32'h4,  0);
        add(1,1,1,32'h302, 0,0,     0,0,      1);
        add(1,1,0,0,      1,32'h300,0,0,      0);
        add(1,1,0,0,      1,32'h304,0,0,      0);
        add(1,1,0,0,      1,32'h308,1,32'h300,0);

        wr_req[0] = 0; wr_addr[0] = 32'h0;         wr_valid[0] = 0; wr_pc[0] = 32'h0;
        wr_req[1] = 1; wr_addr[1] = 32'hFFFF_FFF8; wr_valid[1] = 0; wr_pc[1] = 32'h0;
        wr_req[2] = 1; wr_addr[2] = 32'hFFFF_FFFC; wr_valid[2] = 0; wr_pc[2] = 32'h0;
        wr_req[3] = 1; wr_addr[3] = 32'h0;         wr_valid[3] = 1; wr_pc[3] = 32'hFFFF_FFF8;
        wr_req[4] = 1; wr_addr[4] = 32'h4;         wr_valid[4] = 1; wr_pc[4] = 32'hFFFF_FFFC;
        wr_req[5] = 1; wr_addr[5] = 32'h8;         wr_valid[5] = 1; wr_pc[5] = 32'h0;
        wr_req[6] = 1; wr_addr[6] = 32'hC;         wr_valid[6] = 1; wr_pc[6] = 32'h4;

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            rst_n          = tbl[i].rst_n;
            id_ready       = tbl[i].rdy;
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            @(negedge clk);
            chk("imem_req", i, 32'(imem_req), 32'(tbl[i].e_req));
            if (tbl[i].e_req) chk("imem_addr", i, imem_addr, tbl[i].e_addr);
            chk("if_valid", i, 32'(if_valid), 32'(tbl[i].e_valid));
            if (tbl[i].e_valid) begin
                chk("if_pc", i, if_pc, tbl[i].e_pc);
                chk("if_instr", i, if_instr, mem_word(tbl[i].e_pc));
            end
            if (tbl[i].e_zero) begin
                chk("if_pc_zero", i, if_pc, 32'h0);
                chk("if_instr_zero", i, if_instr, 32'h0);
            end
        end

        // address wrap from RESET_PC near the top of the space
        for (int k = 0; k < 7; k++) begin
            @(posedge clk);
            #1;
            w_rst_n = 1'b1;
            @(negedge clk);
            chk("wrap_req", k, 32'(w_req), 32'(wr_req[k]));
            if (wr_req[k]) chk("wrap_addr", k, w_addr, wr_addr[k]);
            chk("wrap_valid", k, 32'(w_valid), 32'(wr_valid[k]));
            if (wr_valid[k]) begin
                chk("wrap_pc", k, w_pc, wr_pc[k]);
                chk("wrap_instr", k, w_instr, mem_word(wr_pc[k]));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
